// File: rtl/dsp_mavg_regif.sv
// Register-mapped moving-average engine fed by the AHB slave request stream.
// Ports: i_clk_ahb/i_rst_ahb (async active-high), i_valid/i_rd0_wr1/i_addr/
// i_wr_data request in; o_ready, o_rd_valid/o_rd_data read response;
// o_avg/o_avg_valid streaming average. Optional macro: DSP_MAVG_ROUND_EN
// (round-half-up average instead of truncation toward -infinity).
module dsp_mavg_regif #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SAMPLE_WIDTH = 16,
  parameter int DEPTH        = 8
) (
  input  logic                  i_clk_ahb,
  input  logic                  i_rst_ahb,
  input  logic                  i_valid,
  input  logic                  i_rd0_wr1,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_ready,
  output logic                  o_rd_valid,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic [DATA_WIDTH-1:0] o_avg,
  output logic                  o_avg_valid
);

  localparam int LOG2 = $clog2(DEPTH);
  localparam int SW   = SAMPLE_WIDTH + LOG2;
  localparam int CW   = LOG2 + 1;
  localparam int WW   = DATA_WIDTH + SW + 1;

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_SAMPLE = 3'd1;
  localparam logic [2:0] OFF_AVG    = 3'd2;
  localparam logic [2:0] OFF_STATUS = 3'd3;
  localparam logic [2:0] OFF_SCNT   = 3'd4;

  typedef enum logic {S_IDLE, S_UPDATE} state_t;

  state_t                  state_q, state_d;
  logic                    en_q, en_d;
  logic [SAMPLE_WIDTH-1:0] sample_q, sample_d;
  logic [SW-1:0]           sum_q, sum_d;
  logic [LOG2-1:0]         wptr_q, wptr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [31:0]             scnt_q, scnt_d;
  logic [SAMPLE_WIDTH-1:0] buf_q [DEPTH];
  logic [SAMPLE_WIDTH-1:0] buf_d [DEPTH];
  logic [DATA_WIDTH-1:0]   avg_q, avg_d;
  logic                    avg_vld_q, avg_vld_d;
  logic                    rd_vld_q, rd_vld_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;

  logic                    acc;
  logic [2:0]              off;
  logic [DATA_WIDTH-1:0]   rd_mux;
  logic [DATA_WIDTH-1:0]   status;
  logic [SAMPLE_WIDTH-1:0] old;
  logic [SW-1:0]           samp_x, old_x;
  logic signed [WW-1:0]    wide, wide_sh;
  logic                    unused;

  assign o_ready     = (state_q == S_IDLE);
  assign o_rd_valid  = rd_vld_q;
  assign o_rd_data   = rd_data_q;
  assign o_avg       = avg_q;
  assign o_avg_valid = avg_vld_q;

  assign acc = i_valid && o_ready;
  assign off = i_addr[4:2];
  assign unused = ^{i_addr, i_wr_data, wide_sh};

  always_comb begin
    status       = '0;
    status[15:8] = 8'(cnt_q);
    status[1]    = (cnt_q == '0);
    status[0]    = (cnt_q == CW'(DEPTH));
    case (off)
      OFF_CTRL:   rd_mux = DATA_WIDTH'(en_q);
      OFF_AVG:    rd_mux = avg_q;
      OFF_STATUS: rd_mux = status;
      OFF_SCNT:   rd_mux = DATA_WIDTH'(scnt_q);
      default:    rd_mux = '0;
    endcase
  end

  // Running-sum update; empty slots hold 0 so the oldest value is
  // always the one subtracted, before and after the window fills.
  always_comb begin
    old    = buf_q[wptr_q];
    samp_x = {{LOG2{sample_q[SAMPLE_WIDTH-1]}}, sample_q};
    old_x  = {{LOG2{old[SAMPLE_WIDTH-1]}}, old};
  end

  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    sample_d  = sample_q;
    sum_d     = sum_q;
    wptr_d    = wptr_q;
    cnt_d     = cnt_q;
    scnt_d    = scnt_q;
    buf_d     = buf_q;
    avg_d     = avg_q;
    avg_vld_d = 1'b0;
    rd_vld_d  = 1'b0;
    rd_data_d = rd_data_q;
    wide      = '0;
    wide_sh   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (acc && !i_rd0_wr1) begin
          rd_vld_d  = 1'b1;
          rd_data_d = rd_mux;
        end else if (acc) begin
          if (off == OFF_CTRL) begin
            en_d = i_wr_data[0];
            if (i_wr_data[1]) begin
              buf_d  = '{default: '0};
              sum_d  = '0;
              cnt_d  = '0;
              wptr_d = '0;
              scnt_d = '0;
              avg_d  = '0;
            end
          end else if (off == OFF_SAMPLE && en_q) begin
            sample_d = i_wr_data[SAMPLE_WIDTH-1:0];
            state_d  = S_UPDATE;
          end
        end
      end
      S_UPDATE: begin
        sum_d         = sum_q + samp_x - old_x;
        buf_d[wptr_q] = sample_q;
        wptr_d        = wptr_q + 1'b1;
        if (cnt_q != CW'(DEPTH)) cnt_d = cnt_q + 1'b1;
        scnt_d        = scnt_q + 32'd1;
        wide          = {{(WW-SW){sum_d[SW-1]}}, sum_d};
`ifdef DSP_MAVG_ROUND_EN
        wide          = wide + WW'(DEPTH / 2);
`else
        wide          = wide;
`endif
        wide_sh       = wide >>> LOG2;
        avg_d         = wide_sh[DATA_WIDTH-1:0];
        avg_vld_d     = 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_ahb or posedge i_rst_ahb) begin
    if (i_rst_ahb) begin
      state_q   <= S_IDLE;
      en_q      <= 1'b0;
      sample_q  <= '0;
      sum_q     <= '0;
      wptr_q    <= '0;
      cnt_q     <= '0;
      scnt_q    <= '0;
      buf_q     <= '{default: '0};
      avg_q     <= '0;
      avg_vld_q <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      sample_q  <= sample_d;
      sum_q     <= sum_d;
      wptr_q    <= wptr_d;
      cnt_q     <= cnt_d;
      scnt_q    <= scnt_d;
      buf_q     <= buf_d;
      avg_q     <= avg_d;
      avg_vld_q <= avg_vld_d;
      rd_vld_q  <= rd_vld_d;
      rd_data_q <= rd_data_d;
    end
  end

endmodule
